// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32 opcode constants, reset PC and fetch-state encoding
package cpu_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BUBBLE = 7'h00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: valid/ready instruction-memory read channel
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and fetch stage with redirect and in-flight squash
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                stall,
  output logic                instr_valid,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     pc_out,
  output logic [XLEN-1:0]     pc_plus4,
  output logic [6:0]          opcode,
  output logic                misalign_err
);
  fetch_state_e    state, state_nx;
  logic [XLEN-1:0] fetch_pc, drain_addr;
  logic            xfer, park;
  // A redirect cannot withdraw an unaccepted request, so it parks the old address in DRAIN
  assign imem.imem_req  = state == ST_FETCH ? (~instr_valid | ~stall) : state == ST_DRAIN;
  assign imem.imem_addr = state == ST_DRAIN ? drain_addr : fetch_pc;
  assign xfer     = imem.imem_req & imem.imem_ready;
  assign park     = state == ST_FETCH & redirect & imem.imem_req & ~imem.imem_ready;
  assign pc_plus4 = pc_out + XLEN'(4);
  assign opcode   = instr_valid ? instr[6:0] : OPC_BUBBLE;
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_nx;
  end
  // next state: IDLE lasts one cycle; DRAIN holds until the stale transfer completes
  always_comb begin
    state_nx = state == ST_IDLE ? ST_FETCH :
               park ? ST_DRAIN :
               (state == ST_DRAIN & ~imem.imem_ready) ? ST_DRAIN : ST_FETCH;
  end
  // PC, drain address and output pipeline register; redirect beats stall and transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      drain_addr   <= '0;
      instr_valid  <= 1'b0;
      instr        <= '0;
      pc_out       <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect & |redirect_pc[1:0];
      if (park) drain_addr <= imem.imem_addr;
      if (redirect) begin
        fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
        instr_valid <= 1'b0;
      end else if (state == ST_FETCH && xfer) begin
        instr       <= imem.imem_rdata;
        pc_out      <= fetch_pc;
        instr_valid <= 1'b1;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end else if (state == ST_FETCH && !stall) begin
        instr_valid <= 1'b0;
      end
    end
  end
endmodule
